processor_v2: RTL and testbench
===============================

# processor_v2

Parametrised second-generation single-issue datapath: register file, immediate/register operand mux, 8-function ALU, and a two-stage issue/writeback pipeline with a valid/ready instruction handshake. It adds status flags, a registered result port, back-to-back hazard handling and a debug read port. It sits between the instruction source (bench or sequencer) and any consumer of `Result`.

## Interface
- `DATA_W`, 8: register and ALU width; minimum 4.
- `NREGS`, 4: register count; power of two, minimum 2; `AW = $clog2(NREGS)`.
- `Clock_50`  in  1  sole clock; all state updates on its rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `In_valid`  in  1  instruction fields valid.
- `In_ready`  out  1  block can accept; transfer when `In_valid && In_ready` at a rising edge.
- `W_addr`  in  AW  destination register.
- `W_en`  in  1  write result to `W_addr`.
- `RA_addr`, `RB_addr`  in  AW  source registers.
- `Imm`  in  DATA_W  immediate operand.
- `A_sel`  in  1  1: operand A = `Imm`; 0: operand A = R[`RA_addr`].
- `F`  in  3  ALU function.
- `Result`  out  DATA_W  registered ALU result of the last accepted instruction.
- `Result_valid`  out  1  one-cycle pulse per accepted instruction.
- `Flag_Z`, `Flag_N`, `Flag_C`  out  1 each  zero, MSB and carry of the last result.
- `Dbg_addr`  in  AW;  `Dbg_data`  out  DATA_W  combinational read of R[`Dbg_addr`].

## Operation
- Operand B is always R[`RB_addr`].
- F: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 PASS A; 101 XOR; 110 SHL1 A; 111 SHR1 A (logical).
- Arithmetic is modulo 2^DATA_W.
- C: ADD carry-out; SUB 1 = no borrow (A >= B unsigned); SHL1 old A[MSB]; SHR1 old A[0]; all other ops 0.
- Z = (result == 0); N = result[DATA_W-1].
- Stage 1 (issue), on accept: read operands and compute the ALU result. Load `Result`, the flags and the WB register (`wb_valid`, `wb_en`, `wb_addr`, `wb_data`). Pulse `Result_valid`.
- Stage 2 (writeback): if `wb_valid && wb_en`, R[`wb_addr`] <= `wb_data` at the next edge.
- Hazard: the issuing instruction reads RA (when `A_sel=0`) or RB equal to `wb_addr`, with `wb_valid && wb_en`.
- No accept cycle: `wb_valid` <= 0. `Result` and the flags hold.
- Both reads and writes target R0; there is no hardwired-zero register.

## Timing
- Reset values: all registers 0, `wb_valid` 0, `Result` 0, `Result_valid` 0, all flags 0, `In_ready` 1.
- The reset is asserted asynchronously and its release is synchronised. A pending writeback is discarded.
- Latency: `Result` and the flags are visible 1 cycle after accept. The register file is updated 2 edges after accept, so `Dbg_data` reflects it from then.
- `In_ready` depends only on state and on the current instruction fields; it never depends on `Result`.
- If `In_valid` is low, the fields are ignored and no state changes except clearing `wb_valid`.
- Simultaneous writeback and `Dbg_addr` read of the same register: `Dbg_data` shows the old value until the edge.

## Configuration
- `PROC_V2_FORWARD_EN` defined:
  - On a hazard, `wb_data` is forwarded to the matching operand.
  - `In_ready` is constantly 1 out of reset, giving 1 instruction per cycle.
- `PROC_V2_FORWARD_EN` undefined:
  - On a hazard, `In_ready` = 0 for exactly one cycle while the writeback completes, then 1.
  - The held instruction is accepted next cycle with the updated register value.
  - Results are identical in both configurations; only throughput differs.

## Structure
- Package `processor_v2_pkg`:
  - F encodings as a typedef enum (`ALU_ADD` .. `ALU_SHR`).
  - The flag struct {Z, N, C}.
  - The minimum-width checks.
- Sub-module `alu_v2`: purely combinational, parametrised by `DATA_W`, inputs A/B/F, outputs result and flags.
- Register file, forwarding/stall logic and pipeline registers stay in `processor_v2`.

## Test plan
- **Reset mid-operation:** assert `Resetn` low while a write is pending in WB -> `Dbg_data` = 0 for every address; `Result`, the flags and `Result_valid` = 0; `In_ready` = 1.
- **Back-to-back hazards** (default params, `In_valid` high each cycle):
  - Instructions: R0=0x55^R0 (F=101, A_sel=1); R1=0x25+R0 (F=000, RB=0); R2=PASS 0x0F (F=100, RB=1); R3=0xB0^R2 (F=101, RB=2).
  - Required: R0..R3 = 0x55, 0x7A, 0x0F, 0xBF. `Result` sequence is the same.
  - With forwarding: 4 accepts in 4 cycles. Without forwarding: `In_ready` drops 3 times, one cycle each.
- **ADD overflow:** R0=0xFF, then ADD Imm 0x01 + R0 -> `Result` 0x00, Z=1, C=1, N=0.
- **SUB borrow:** Imm 0x03 - R[RB]=0x05 -> 0xFE, C=0, N=1; 0x05 - 0x03 -> 0x02, C=1.
- **Shifts:** SHL1 0x81 -> 0x02, C=1; SHR1 0x01 -> 0x00, Z=1, C=1.
- **Wider configuration:** DATA_W=16, NREGS=8. Write 0xBEEF to R7 with `W_en`=0, then 0x1234 with `W_en`=1 -> R7 = 0x1234, `Result_valid` pulsed twice; idle cycle -> `Result` held.

Source files
------------

// File: rtl/processor_v2_pkg.sv
// Shared types for processor_v2: ALU function codes, flag bundle and parameter sanity checks.
package processor_v2_pkg;

    localparam int unsigned MIN_DATA_W = 4;
    localparam int unsigned MIN_NREGS  = 2;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_PASS = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_SHL  = 3'b110,
        ALU_SHR  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } alu_flags_t;

    function automatic bit params_ok(input int unsigned data_w, input int unsigned nregs);
        return (data_w >= MIN_DATA_W) && (nregs >= MIN_NREGS) && ((nregs & (nregs - 1)) == 0);
    endfunction

endpackage

// File: rtl/alu_v2.sv
// Combinational 8-function ALU producing the result plus zero/negative/carry flags.
module alu_v2
    import processor_v2_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           f,
    output logic [DATA_W-1:0] result,
    output alu_flags_t        flags
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (f)
            ALU_ADD:  {carry, result} = sum;
            // Carry on subtract means "no borrow", i.e. a >= b unsigned
            ALU_SUB:  begin result = diff[DATA_W-1:0]; carry = ~diff[DATA_W]; end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_PASS: result = a;
            ALU_XOR:  result = a ^ b;
            ALU_SHL:  begin result = {a[DATA_W-2:0], 1'b0}; carry = a[DATA_W-1]; end
            ALU_SHR:  begin result = {1'b0, a[DATA_W-1:1]}; carry = a[0]; end
            default:  ;
        endcase
    end

    always_comb begin
        flags   = '0;
        flags.z = (result == '0);
        flags.n = result[DATA_W-1];
        flags.c = carry;
    end

endmodule

// File: rtl/processor_v2.sv
// Two-stage issue/writeback datapath with register file, ALU, flags and debug read port.
// Define PROC_V2_FORWARD_EN to forward writeback data instead of stalling on hazards.
module processor_v2
    import processor_v2_pkg::*;
#(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned NREGS  = 4,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [AW-1:0]     W_addr,
    input  logic              W_en,
    input  logic [AW-1:0]     RA_addr,
    input  logic [AW-1:0]     RB_addr,
    input  logic [DATA_W-1:0] Imm,
    input  logic              A_sel,
    input  logic [2:0]        F,
    output logic [DATA_W-1:0] Result,
    output logic              Result_valid,
    output logic              Flag_Z,
    output logic              Flag_N,
    output logic              Flag_C,
    input  logic [AW-1:0]     Dbg_addr,
    output logic [DATA_W-1:0] Dbg_data
);

    if (!params_ok(DATA_W, NREGS)) begin : g_param_check
        $error("processor_v2: DATA_W must be >= 4 and NREGS a power of two >= 2");
    end

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wb_valid_q;
    logic              wb_en_q;
    logic [AW-1:0]     wb_addr_q;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    alu_flags_t        flags_q;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    alu_flags_t        alu_flags;
    logic              hit_a;
    logic              hit_b;
    logic              accept;

    // Assert immediately, release two edges after Resetn rises
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    // wb_data is the registered result itself: both load on accept and hold otherwise
    assign hit_a = wb_valid_q && wb_en_q && !A_sel && (RA_addr == wb_addr_q);
    assign hit_b = wb_valid_q && wb_en_q && (RB_addr == wb_addr_q);

`ifdef PROC_V2_FORWARD_EN
    assign In_ready = 1'b1;
    assign op_a     = A_sel ? Imm : (hit_a ? result_q : regs_q[RA_addr]);
    assign op_b     = hit_b ? result_q : regs_q[RB_addr];
`else
    assign In_ready = !(hit_a || hit_b);
    assign op_a     = A_sel ? Imm : regs_q[RA_addr];
    assign op_b     = regs_q[RB_addr];
`endif

    assign accept = In_valid && In_ready;

    alu_v2 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .f      (alu_op_e'(F)),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge Clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_valid_q && wb_en_q) begin
            regs_q[wb_addr_q] <= result_q;
        end
    end

    always_ff @(posedge Clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q     <= 1'b0;
            wb_en_q        <= 1'b0;
            wb_addr_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            flags_q        <= '0;
        end else begin
            wb_valid_q     <= accept;
            result_valid_q <= accept;
            if (accept) begin
                wb_en_q   <= W_en;
                wb_addr_q <= W_addr;
                result_q  <= alu_result;
                flags_q   <= alu_flags;
            end
        end
    end

    assign Result       = result_q;
    assign Result_valid = result_valid_q;
    assign Flag_Z       = flags_q.z;
    assign Flag_N       = flags_q.n;
    assign Flag_C       = flags_q.c;
    assign Dbg_data     = regs_q[Dbg_addr];

endmodule

// File: tb/tb_processor_v2.sv
// Self-checking bench for processor_v2: vector table, hazard/reset sequences, random vs reference model.
module tb_processor_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic       resetn, in_valid, in_ready, w_en, a_sel, result_valid, flag_z, flag_n, flag_c;
    logic [1:0] w_addr, ra_addr, rb_addr, dbg_addr;
    logic [7:0] imm, result, dbg_data;
    logic [2:0] f;

    // wide DUT
    logic        wresetn, wv, wrdy, wwen, wasel, wrv, wz, wn, wc;
    logic [2:0]  wwa, wra, wrb, wdbga, wf;
    logic [15:0] wimm, wres, wdbgd;

    processor_v2 u_dut (
        .Clock_50(clk), .Resetn(resetn), .In_valid(in_valid), .In_ready(in_ready),
        .W_addr(w_addr), .W_en(w_en), .RA_addr(ra_addr), .RB_addr(rb_addr), .Imm(imm),
        .A_sel(a_sel), .F(f), .Result(result), .Result_valid(result_valid), .Flag_Z(flag_z),
        .Flag_N(flag_n), .Flag_C(flag_c), .Dbg_addr(dbg_addr), .Dbg_data(dbg_data)
    );

    processor_v2 #(.DATA_W(16), .NREGS(8)) u_dut_wide (
        .Clock_50(clk), .Resetn(wresetn), .In_valid(wv), .In_ready(wrdy),
        .W_addr(wwa), .W_en(wwen), .RA_addr(wra), .RB_addr(wrb), .Imm(wimm),
        .A_sel(wasel), .F(wf), .Result(wres), .Result_valid(wrv), .Flag_Z(wz),
        .Flag_N(wn), .Flag_C(wc), .Dbg_addr(wdbga), .Dbg_data(wdbgd)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Architectural model: arch holds every accepted write, cmt what the register file shows
    logic [7:0] arch [4];
    logic [7:0] cmt  [4];
    logic       pend_v;
    logic [1:0] pend_a;
    logic [7:0] pend_d;
    logic [7:0] exp_res;
    logic       exp_z, exp_n, exp_c;

    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] fn);
        int   ai, bi, r;
        logic c;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 1'b0;
        case (fn)
            3'd0: begin r = ai + bi; c = (r > 255); end
            3'd1: begin r = ai - bi; c = (ai >= bi); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = ai;
            3'd5: r = int'(a ^ b);
            3'd6: begin r = ai * 2; c = (ai >= 128); end
            default: begin r = ai / 2; c = ((ai % 2) == 1); end
        endcase
        r = ((r % 256) + 256) % 256;
        return {c, r[7:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            arch[i] = 8'h00;
            cmt[i]  = 8'h00;
        end
        pend_v  = 1'b0;
        pend_a  = 2'd0;
        pend_d  = 8'h00;
        exp_res = 8'h00;
        exp_z   = 1'b0;
        exp_n   = 1'b0;
        exp_c   = 1'b0;
    endtask

    // One clock cycle: drive, check readiness, clock, check outputs against the model
    task automatic step(input logic v, input logic we, input logic [1:0] wa, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [7:0] im, input logic as,
                        input logic [2:0] fn, input logic [1:0] da, output logic acc);
        logic       exp_rdy;
        logic [8:0] cr;
        logic [7:0] opa;
        in_valid = v; w_en = we; w_addr = wa; ra_addr = ra; rb_addr = rb;
        imm = im; a_sel = as; f = fn; dbg_addr = da;
        #1;
`ifdef PROC_V2_FORWARD_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = !(pend_v && ((!as && ra == pend_a) || rb == pend_a));
`endif
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("dbg_before_edge", 32'(dbg_data), 32'(cmt[da]));
        acc = v && in_ready;
        cr  = 9'h000;
        if (acc) begin
            opa     = as ? im : arch[ra];
            cr      = ref_alu(opa, arch[rb], fn);
            exp_res = cr[7:0];
            exp_z   = (cr[7:0] == 8'h00);
            exp_n   = (cr[7:0] >= 8'h80);
            exp_c   = cr[8];
        end
        @(posedge clk);
        #1;
        if (pend_v) cmt[pend_a] = pend_d;
        pend_v = acc && we;
        pend_a = wa;
        pend_d = cr[7:0];
        if (acc && we) arch[wa] = cr[7:0];
        chk("result", 32'(result), 32'(exp_res));
        chk("flag_z", 32'(flag_z), 32'(exp_z));
        chk("flag_n", 32'(flag_n), 32'(exp_n));
        chk("flag_c", 32'(flag_c), 32'(exp_c));
        chk("result_valid", 32'(result_valid), 32'(acc));
        chk("dbg_after_edge", 32'(dbg_data), 32'(cmt[da]));
    endtask

    typedef struct {
        logic       we;
        logic [1:0] wa, ra, rb;
        logic [7:0] im;
        logic       as;
        logic [2:0] fn;
        logic [7:0] er;
        logic       ez, en, ec;
    } vec_t;

    vec_t vecs [16];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic       acc;
        int         tries, stalls, pulses;
        logic [7:0] hz_want [4];

        // we  wa    ra    rb    imm    as    fn    result z     n     c
        vecs[0]  = '{1'b1, 2'd0, 2'd0, 2'd0, 8'h55, 1'b1, 3'd5, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 2'd0, 2'd0, 8'h25, 1'b1, 3'd0, 8'h7A, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 2'd0, 2'd1, 8'h0F, 1'b1, 3'd4, 8'h0F, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 2'd0, 2'd2, 8'hB0, 1'b1, 3'd5, 8'hBF, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 2'd0, 2'd3, 8'hFF, 1'b1, 3'd4, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 2'd0, 2'd1, 8'h05, 1'b1, 3'd4, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 2'd0, 2'd2, 8'h03, 1'b1, 3'd1, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 2'd0, 2'd0, 8'h03, 1'b1, 3'd4, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 2'd0, 2'd3, 8'h05, 1'b1, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'd1, 2'd0, 2'd0, 8'h81, 1'b1, 3'd6, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'd1, 2'd0, 2'd0, 8'h01, 1'b1, 3'd7, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 2'd1, 2'd2, 2'd3, 8'hAA, 1'b0, 3'd3, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 2'd1, 2'd2, 8'hAA, 1'b0, 3'd2, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'd0, 2'd2, 2'd2, 8'hAA, 1'b0, 3'd1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 2'd3, 2'd0, 2'd1, 8'hAA, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0, 1'b0};
        hz_want = '{8'h55, 8'h7A, 8'h0F, 8'hBF};

        resetn = 1'b0; in_valid = 1'b0; w_en = 1'b0; w_addr = 2'd0; ra_addr = 2'd0;
        rb_addr = 2'd0; imm = 8'h00; a_sel = 1'b0; f = 3'd0; dbg_addr = 2'd0;
        wresetn = 1'b0; wv = 1'b0; wwen = 1'b0; wwa = 3'd0; wra = 3'd0; wrb = 3'd0;
        wimm = 16'h0000; wasel = 1'b0; wf = 3'd0; wdbga = 3'd0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_valid", 32'(result_valid), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_n, flag_c}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("rst_dbg", 32'(dbg_data), 32'd0);
        end
        resetn  = 1'b1;
        wresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Wide configuration: unwritten then written R7, then an idle cycle
        pulses = 0;
        wv = 1'b1; wwa = 3'd7; wwen = 1'b0; wimm = 16'hBEEF; wasel = 1'b1; wf = 3'd4;
        wdbga = 3'd7;
        @(posedge clk);
        #1;
        if (wrv) pulses++;
        chk("wide_result_beef", 32'(wres), 32'h0000BEEF);
        chk("wide_flag_n", 32'(wn), 32'd1);
        wimm = 16'h1234; wwen = 1'b1;
        @(posedge clk);
        #1;
        if (wrv) pulses++;
        chk("wide_result_1234", 32'(wres), 32'h00001234);
        chk("wide_r7_unwritten", 32'(wdbgd), 32'd0);
        wv = 1'b0;
        @(posedge clk);
        #1;
        if (wrv) pulses++;
        chk("wide_result_held", 32'(wres), 32'h00001234);
        chk("wide_r7", 32'(wdbgd), 32'h00001234);
        chk("wide_pulses", 32'(pulses), 32'd2);

        // Vector table; the first four form the back-to-back hazard chain
        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 4) begin
                step(1'b1, vecs[i].we, vecs[i].wa, vecs[i].ra, vecs[i].rb, vecs[i].im,
                     vecs[i].as, vecs[i].fn, 2'(i), acc);
                if (!acc && i < 4) stalls++;
                tries++;
            end
            if (!acc) chk("accept_timeout", 32'(i), 32'hFFFFFFFF);
            chk("vec_result", 32'(result), 32'(vecs[i].er));
            chk("vec_flags", 32'({flag_z, flag_n, flag_c}),
                32'({vecs[i].ez, vecs[i].en, vecs[i].ec}));
            if (i == 3) begin
`ifdef PROC_V2_FORWARD_EN
                chk("hazard_stalls", 32'(stalls), 32'd0);
`else
                chk("hazard_stalls", 32'(stalls), 32'd3);
`endif
                for (int r = 0; r < 4; r++) begin
                    step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0, 3'd0, 2'(r), acc);
                    chk("hazard_reg", 32'(dbg_data), 32'(hz_want[r]));
                end
            end
        end

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
                 2'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), acc);
        end

        // Reset while a write is pending in writeback
        step(1'b1, 1'b1, 2'd2, 2'd0, 2'd0, 8'h5A, 1'b1, 3'd4, 2'd2, acc);
        resetn = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_result_valid", 32'(result_valid), 32'd0);
        chk("midrst_flags", 32'({flag_z, flag_n, flag_c}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("midrst_dbg", 32'(dbg_data), 32'd0);
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        dbg_addr = 2'd2;
        #1;
        chk("midrst_wb_discarded", 32'(dbg_data), 32'd0);
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom),
                 1'($urandom), 3'($urandom), 2'($urandom), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
